// File: rtl/cpu_ctrl.sv
// Purpose: instruction-register and control FSM that sequences datapath enables for MOV/ADD/AND/CMP/MVN.
// Latency: MOV imm 3, MOV reg/CMP/MVN 5, ADD/AND 6, unsupported 2 edges from the accepting edge back to WAIT.
// Backpressure: w=1 only in WAIT; s is ignored and the instruction register holds while busy.
module cpu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [15:0] sximm8,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GETA   = 3'd2,
        S_GETB   = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5,
        S_WRIMM  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    // Fields of the latched instruction; outputs never look at the live input.
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    // Instruction classes.
    logic is_movi;
    logic is_movr;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign w      = (state == S_WAIT);
    assign bsel   = 1'b0;

    // Capture the instruction only on the accepting edge; reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if ((state == S_WAIT) && s) begin
            ir <= in;
        end
    end

    // State register; reset wins over everything and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection per instruction class.
    always_comb begin
        state_nxt = S_WAIT;
        case (state)
            S_WAIT:   state_nxt = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (is_movi) begin
                    state_nxt = S_WRIMM;
                end else if (is_movr || is_mvn) begin
                    state_nxt = S_GETB;
                end else if (is_alu) begin
                    state_nxt = S_GETA;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_GETA:   state_nxt = S_GETB;
            S_GETB:   state_nxt = S_EXEC;
            S_EXEC:   state_nxt = is_cmp ? S_WAIT : S_WRITE;
            S_WRITE:  state_nxt = S_WAIT;
            S_WRIMM:  state_nxt = S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    // Moore control outputs: everything zero unless the current state drives it.
    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state)
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                ALUop = is_movr ? 2'b00 : op;
                // MOV reg and MVN use only the B operand, so A is forced to zero.
                asel  = is_movr || is_mvn;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            S_WRITE: begin
                writenum = rd;
                vsel     = 1'b0;
                write    = 1'b1;
            end
            S_WRIMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock domain:
  clk  input  1  rising-edge clock, same clock as the datapath
  reset  input  1  synchronous, active-high reset
  s  input  1  start pulse; sampled only in WAIT
  in  input  16  instruction word
  w  output  1  1 = idle in WAIT, ready for s
  sximm8  output  16  sign-extended in[7:0] of latched instruction, drives datapath_in
  readnum, writenum  output  3  register-file read and write index
  vsel  output  1  1 = write-back datapath_in, 0 = write-back C
  loada, loadb, loadc, loads, write  output  1  datapath load and write enables
  asel  output  1  1 = A operand forced to 0
  bsel  output  1  held 0
  shift, ALUop  output  2  shifter op and ALU op

Function
REQ-002 The block SHALL latch in[15:0] into an instruction register only on an edge with state=WAIT and s=1.
REQ-003 Field decode SHALL be: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0], all taken from the latched instruction.
REQ-004 The FSM SHALL have the states WAIT, DECODE, GETA, GETB, EXEC, WRITE and WRIMM.
REQ-005 All control outputs SHALL be Moore outputs of the state and the latched fields; every enable SHALL be 0 in WAIT and DECODE.
REQ-006 The state transitions SHALL be:
  WAIT->DECODE when s=1.
  DECODE, opcode 110, op 10 (MOV imm) -> WRIMM -> WAIT.
  DECODE, opcode 110, op 00 (MOV reg) -> GETB -> EXEC -> WRITE -> WAIT.
  DECODE, opcode 101, op 00 (ADD) or op 10 (AND) -> GETA -> GETB -> EXEC -> WRITE -> WAIT.
  DECODE, opcode 101, op 01 (CMP) -> GETA -> GETB -> EXEC -> WAIT.
  DECODE, opcode 101, op 11 (MVN) -> GETB -> EXEC -> WRITE -> WAIT.
  DECODE, any other encoding -> WAIT, with no enable asserted.
REQ-007 The per-state outputs SHALL be:
  GETA: readnum=Rn, loada=1.
  GETB: readnum=Rm, loadb=1.
  EXEC: shift=sh, ALUop=op; ALUop=00 for MOV reg; asel=1 for MOV reg and MVN, else 0; loadc=1 except for CMP; loads=1 for CMP only.
  WRITE: writenum=Rd, vsel=0, write=1.
  WRIMM: writenum=Rn, vsel=1, write=1.
REQ-008 sximm8 SHALL equal {{8{imm8[7]}},imm8} at all times.
REQ-009 w SHALL be 1 if and only if state=WAIT.
REQ-010 s SHALL be ignored in every state other than WAIT, and the instruction register SHALL NOT change while busy.
REQ-011 The number of edges from the accepting edge back to WAIT SHALL be: MOV imm 3, MOV reg 5, ADD/AND 6, CMP 5, MVN 5, unsupported 2.
REQ-012 If s=1 on the edge that enters WAIT, the block SHALL NOT start; a new start requires s=1 while w=1.
REQ-013 Any state output that REQ-007 does not define SHALL be 0.

Reset
REQ-014 When reset=1 on an edge, the block SHALL enter WAIT and clear the instruction register to 0 (sximm8=0), regardless of the current state.
REQ-015 After reset, w SHALL be 1 and every other output SHALL be 0.
REQ-016 Reset SHALL take priority over s.
REQ-017 A reset during any state SHALL suppress all later enables of the aborted instruction.

Verification
REQ-018 Reset: assert reset for 1 edge from any state -> w=1, all enables 0, sximm8=0x0000.
REQ-019 MOV imm: in=0xD0FD with s=1 -> DECODE, then WRIMM with writenum=0, vsel=1, write=1, sximm8=0xFFFD; w=1 after 3 edges.
REQ-020 ADD: in=0xA148 -> GETA (readnum=1, loada=1), GETB (readnum=0, loadb=1), EXEC (shift=01, ALUop=00, asel=0, loadc=1, loads=0), WRITE (writenum=2, vsel=0, write=1), then WAIT.
REQ-021 CMP: in=0xAB04 -> EXEC has ALUop=01, loads=1, loadc=0; write is never asserted; back in WAIT after 5 edges.
REQ-022 Busy and abort: start in=0xA148, hold s=1 and change in to 0xD0FD during EXEC -> instruction completes unchanged with writenum=2; in a second run, reset=1 in GETB -> WAIT next cycle and write is never asserted.
REQ-023 Unsupported: in=0x0000 with s=1 -> DECODE, then WAIT; every enable stays 0 throughout.
